// File: rtl/nes_poller_if.sv
// rtl/nes_poller_if.sv - poller <-> nes_bridge control/readback bus
//
// Purpose: bundles the signals nes_poller uses to drive a nes_bridge.
// Signals:
//   bridge_start  1  one-cycle start pulse to the bridge
//   bridge_addr   2  bridge readback select (00 ready, 01 valid, 10 joypad)
//   bridge_rdata  8  bridge readback data, combinational from bridge_addr
// Modports:
//   master  poller side (drives start/addr, reads rdata)
//   slave   bridge side (reads start/addr, drives rdata)
interface nes_poller_if;
  logic       bridge_start;
  logic [1:0] bridge_addr;
  logic [7:0] bridge_rdata;

  modport master (
    output bridge_start,
    output bridge_addr,
    input  bridge_rdata
  );

  modport slave (
    input  bridge_start,
    input  bridge_addr,
    output bridge_rdata
  );
endinterface

// File: rtl/nes_poller.sv
// rtl/nes_poller.sv - fixed-rate NES joypad poller with sticky edge masks and IRQ
//
// Purpose: periodically (or on request) runs one nes_bridge transfer, latches
// the button byte and accumulates sticky pressed/released edge masks.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_enable           timed polling on
//   i_poll_now         one-cycle request for an immediate poll
//   i_clear            one-cycle clear of pressed/released/timeout_err
//   bus (master)       bridge_start / bridge_addr / bridge_rdata
//   o_buttons          last good joypad byte, 1 = held
//   o_pressed          sticky 0->1 edges since last clear
//   o_released         sticky 1->0 edges since last clear
//   o_irq              any pressed/released bit or timeout_err
//   o_timeout_err      sticky poll timeout flag
//   o_sample_count     successful polls, wrapping
//   o_busy             a poll is in progress
module nes_poller #(
  parameter int POLL_PERIOD = 833_333,
  parameter int TIMEOUT     = 2_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_poll_now,
  input  logic            i_clear,
  nes_poller_if.master    bus,
  output logic [7:0]      o_buttons,
  output logic [7:0]      o_pressed,
  output logic [7:0]      o_released,
  output logic            o_irq,
  output logic            o_timeout_err,
  output logic [15:0]     o_sample_count,
  output logic            o_busy
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_period_ctr;
  logic [TW-1:0]   r_timeout_ctr;
  logic            r_pending;
  logic [1:0]      r_addr;
  logic [7:0]      r_buttons;
  logic [7:0]      r_pressed;
  logic [7:0]      r_released;
  logic            r_timeout_err;
  logic [15:0]     r_sample_count;

  logic            w_wrap;
  logic            w_timeout_hit;
  logic            w_start;
  logic [1:0]      w_next_addr;
  logic            w_latch;
  logic [7:0]      w_new_pressed;
  logic [7:0]      w_new_released;

  assign w_wrap        = i_enable && (r_period_ctr == PERIOD_LAST);
  // Timeout takes priority over progress so an abort never coincides with a start pulse.
  assign w_timeout_hit = ((r_state == S_ARM) || (r_state == S_WAIT)) &&
                         (r_timeout_ctr == TIMEOUT_LAST);
  assign w_latch        = (r_state == S_LATCH);
  assign w_new_pressed  = w_latch ? (bus.bridge_rdata & ~r_buttons) : 8'h00;
  assign w_new_released = w_latch ? (~bus.bridge_rdata & r_buttons) : 8'h00;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pending) w_next = S_ARM;
      end
      S_ARM: begin
        if (w_timeout_hit)              w_next = S_IDLE;
        else if (bus.bridge_rdata[0])   w_next = S_WAIT;
      end
      S_WAIT: begin
        // Bridge drops valid on the start edge, so a stale valid cannot be seen here.
        if (w_timeout_hit)              w_next = S_IDLE;
        else if (bus.bridge_rdata[0])   w_next = S_LATCH;
      end
      S_LATCH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: start is a same-cycle decode; addr is registered from the next state.
  always_comb begin
    w_start = (r_state == S_ARM) && bus.bridge_rdata[0] && !w_timeout_hit;
    case (w_next)
      S_WAIT:  w_next_addr = 2'b01;
      S_LATCH: w_next_addr = 2'b10;
      default: w_next_addr = 2'b00;
    endcase
  end

  // Timer, request and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_period_ctr   <= '0;
      r_timeout_ctr  <= '0;
      r_pending      <= 1'b0;
      r_addr         <= 2'b00;
      r_buttons      <= 8'h00;
      r_pressed      <= 8'h00;
      r_released     <= 8'h00;
      r_timeout_err  <= 1'b0;
      r_sample_count <= 16'h0000;
    end else begin
      if (!i_enable)   r_period_ctr <= '0;
      else if (w_wrap) r_period_ctr <= '0;
      else             r_period_ctr <= r_period_ctr + 1'b1;

      // A request arriving in the start cycle is kept: it came while busy.
      r_pending <= (r_pending && !w_start) || w_wrap || i_poll_now;

      if (r_state == S_IDLE)
        r_timeout_ctr <= '0;
      else if ((r_state == S_ARM) || (r_state == S_WAIT))
        r_timeout_ctr <= r_timeout_ctr + 1'b1;

      r_addr <= w_next_addr;

      // New edges survive a coincident clear.
      r_pressed  <= (i_clear ? 8'h00 : r_pressed)  | w_new_pressed;
      r_released <= (i_clear ? 8'h00 : r_released) | w_new_released;
      r_timeout_err <= w_timeout_hit || (r_timeout_err && !i_clear);

      if (w_latch) begin
        r_buttons      <= bus.bridge_rdata;
        r_sample_count <= r_sample_count + 16'd1;
      end
    end
  end

  assign bus.bridge_start = w_start;
  assign bus.bridge_addr  = r_addr;

  assign o_buttons      = r_buttons;
  assign o_pressed      = r_pressed;
  assign o_released     = r_released;
  assign o_timeout_err  = r_timeout_err;
  assign o_sample_count = r_sample_count;
  assign o_irq          = (|r_pressed) || (|r_released) || r_timeout_err;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_nes_poller.sv
// tb/tb_nes_poller.sv - self-checking bench for nes_poller with a behavioural bridge
module tb_nes_poller;
  localparam int P = 20;
  localparam int T = 50;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        poll_now;
  logic        clear;
  logic [7:0]  o_buttons;
  logic [7:0]  o_pressed;
  logic [7:0]  o_released;
  logic        o_irq;
  logic        o_timeout_err;
  logic [15:0] o_sample_count;
  logic        o_busy;

  nes_poller_if bus();

  nes_poller #(.POLL_PERIOD(P), .TIMEOUT(T)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_poll_now     (poll_now),
    .i_clear        (clear),
    .bus            (bus),
    .o_buttons      (o_buttons),
    .o_pressed      (o_pressed),
    .o_released     (o_released),
    .o_irq          (o_irq),
    .o_timeout_err  (o_timeout_err),
    .o_sample_count (o_sample_count),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural bridge: start drops ready/valid, valid+ready return tb_lat edges later.
  logic       br_rdy_r;
  logic       br_valid;
  logic [7:0] br_joy;
  int         br_cnt;
  logic       tb_stuck;
  int         tb_lat;
  logic [7:0] tb_next_joy;
  logic       br_ready;

  assign br_ready = br_rdy_r & ~tb_stuck;
  assign bus.bridge_rdata = (bus.bridge_addr == 2'b00) ? {7'b0, br_ready} :
                            (bus.bridge_addr == 2'b01) ? {7'b0, br_valid} : br_joy;

  always @(posedge clk) begin
    if (!rst_n) begin
      br_rdy_r <= 1'b1;
      br_valid <= 1'b0;
      br_joy   <= 8'h00;
      br_cnt   <= 0;
    end else if (bus.bridge_start === 1'b1) begin
      br_rdy_r <= 1'b0;
      br_valid <= 1'b0;
      br_cnt   <= tb_lat;
    end else if (br_cnt != 0) begin
      br_cnt <= br_cnt - 1;
      if (br_cnt == 1) begin
        br_valid <= 1'b1;
        br_rdy_r <= 1'b1;
        br_joy   <= tb_next_joy;
      end
    end
  end

  // Reference model: a poll is "in progress" from the cycle after a pending request is
  // seen while idle; it launches the bridge when ready, waits for valid, spends one
  // cycle taking the byte, and gives up after T cycles without taking it.
  bit         m_live = 0;
  int         m_period;
  bit         m_pend;
  bit         m_inpoll;
  bit         m_launched;
  bit         m_latching;
  int         m_age;
  logic [7:0] m_btn, m_prs, m_rel;
  bit         m_terr;
  logic [15:0] m_cnt;

  function automatic bit exp_start();
    return m_inpoll && !m_launched && !m_latching && br_ready && (m_age != T - 1);
  endfunction

  function automatic logic [1:0] exp_addr();
    if (m_inpoll && m_latching) return 2'b10;
    if (m_inpoll && m_launched) return 2'b01;
    return 2'b00;
  endfunction

  bit         s_wrap, s_go, s_tmo, s_take, s_newp;
  logic [7:0] s_ep, s_er;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1; m_period = 0; m_pend = 0; m_inpoll = 0; m_launched = 0;
      m_latching = 0; m_age = 0; m_btn = 0; m_prs = 0; m_rel = 0; m_terr = 0; m_cnt = 0;
    end else if (m_live) begin
      s_wrap = enable && (m_period == P - 1);
      s_go   = exp_start();
      s_tmo  = m_inpoll && !m_latching && (m_age == T - 1);
      s_take = m_inpoll && m_latching;
      s_newp = (m_pend && !s_go) || s_wrap || poll_now;
      m_period = !enable ? 0 : (s_wrap ? 0 : m_period + 1);
      s_ep = s_take ? (br_joy & ~m_btn) : 8'h00;
      s_er = s_take ? (~br_joy & m_btn) : 8'h00;
      if (!m_inpoll) begin
        if (m_pend) begin m_inpoll = 1; m_launched = 0; m_latching = 0; m_age = 0; end
      end else if (s_take) begin
        m_inpoll = 0; m_latching = 0;
      end else if (s_tmo) begin
        m_inpoll = 0;
      end else begin
        if (!m_launched) begin
          if (s_go) m_launched = 1;
        end else if (br_valid) begin
          m_latching = 1;
        end
        m_age++;
      end
      m_pend = s_newp;
      m_prs  = (clear ? 8'h00 : m_prs) | s_ep;
      m_rel  = (clear ? 8'h00 : m_rel) | s_er;
      m_terr = s_tmo || (m_terr && !clear);
      if (s_take) begin m_btn = br_joy; m_cnt = m_cnt + 16'd1; end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("buttons", o_buttons, m_btn);
      chk("pressed", o_pressed, m_prs);
      chk("released", o_released, m_rel);
      chk("timeout_err", o_timeout_err, m_terr);
      chk("sample_count", o_sample_count, m_cnt);
      chk("busy", o_busy, m_inpoll);
      chk("irq", o_irq, (|m_prs) || (|m_rel) || m_terr);
      chk("bridge_addr", bus.bridge_addr, exp_addr());
      chk("bridge_start", bus.bridge_start, exp_start());
    end
  end

  int n_starts = 0;
  always @(negedge clk) if (rst_n && bus.bridge_start === 1'b1) n_starts++;

  task automatic pulse_poll();
    poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
  endtask

  task automatic wait_count(input logic [15:0] target, input string nm);
    int k = 0;
    while (o_sample_count !== target && k < 300) begin @(negedge clk); k++; end
    chk(nm, o_sample_count, target);
  endtask

  task automatic wait_start(output int k);
    k = 0;
    while (bus.bridge_start !== 1'b1 && k < 300) begin @(negedge clk); k++; end
  endtask

  task automatic start_to_sample(output int m);
    logic [15:0] s0 = o_sample_count;
    m = 0;
    while (o_sample_count === s0 && m < 300) begin @(negedge clk); m++; end
  endtask

  int n, m, s;

  initial begin
    rst_n = 0; enable = 0; poll_now = 0; clear = 0;
    tb_stuck = 0; tb_lat = 10; tb_next_joy = 8'h05;
    repeat (3) @(negedge clk);
    chk("rst_buttons", o_buttons, 8'h00);
    chk("rst_count", o_sample_count, 16'h0);
    chk("rst_addr", bus.bridge_addr, 2'b00);

    // 1) first timed poll
    rst_n = 1; enable = 1;
    wait_start(n);
    chk("first_start_cycle", n, 21);
    start_to_sample(m);
    chk("start_to_sample", m, 13);
    chk("t1_buttons", o_buttons, 8'h05);
    chk("t1_pressed", o_pressed, 8'h05);
    chk("t1_count", o_sample_count, 16'd1);
    chk("t1_irq", o_irq, 1'b1);

    // 2) second poll, then clear
    tb_next_joy = 8'h06;
    wait_count(16'd2, "t2_wait");
    chk("t2_buttons", o_buttons, 8'h06);
    chk("t2_pressed", o_pressed, 8'h07);
    chk("t2_released", o_released, 8'h01);
    clear = 1; @(negedge clk); clear = 0;
    chk("t2_clr_pressed", o_pressed, 8'h00);
    chk("t2_clr_released", o_released, 8'h00);
    chk("t2_clr_irq", o_irq, 1'b0);

    // 3) bridge never ready -> timeout
    enable = 0;
    repeat (40) @(negedge clk);
    s = o_sample_count;
    tb_stuck = 1;
    pulse_poll();
    n = 1;
    while (!o_timeout_err && n < 300) begin @(negedge clk); n++; end
    chk("t3_timeout_cycle", n, 52);
    chk("t3_terr", o_timeout_err, 1'b1);
    chk("t3_busy", o_busy, 1'b0);
    chk("t3_buttons", o_buttons, 8'h06);
    tb_stuck = 0;
    wait_count(16'(s + 1), "t3_recover");
    clear = 1; @(negedge clk); clear = 0;
    chk("t3_clr_terr", o_timeout_err, 1'b0);

    // 4) manual polls and request collapsing
    repeat (5) @(negedge clk);
    s = n_starts; n = o_sample_count;
    pulse_poll();
    wait_count(16'(n + 1), "t4_single");
    repeat (20) @(negedge clk);
    chk("t4_one_start", n_starts - s, 1);
    s = n_starts; n = o_sample_count;
    pulse_poll();
    repeat (2) @(negedge clk); pulse_poll();
    repeat (2) @(negedge clk); pulse_poll();
    repeat (2) @(negedge clk); pulse_poll();
    repeat (80) @(negedge clk);
    chk("t4_starts", n_starts - s, 2);
    chk("t4_samples", o_sample_count, 16'(n + 2));

    // 5) stale valid from the previous transfer is ignored
    tb_lat = 6;
    pulse_poll();
    wait_start(n);
    start_to_sample(m);
    chk("t5_stale_latency", m, 9);

    // 6) clear coincident with the byte capture; reset during bridge wait
    tb_lat = 10; tb_next_joy = 8'h00;
    repeat (5) @(negedge clk);
    n = o_sample_count;
    pulse_poll();
    wait_count(16'(n + 1), "t6_zero");
    tb_next_joy = 8'h80;
    pulse_poll();
    n = 0;
    while (bus.bridge_addr !== 2'b10 && n < 300) begin @(negedge clk); n++; end
    clear = 1; @(negedge clk); clear = 0;
    chk("t6_pressed", o_pressed, 8'h80);
    chk("t6_released", o_released, 8'h00);
    chk("t6_buttons", o_buttons, 8'h80);
    repeat (3) @(negedge clk);
    pulse_poll();
    n = 0;
    while (bus.bridge_addr !== 2'b01 && n < 300) begin @(negedge clk); n++; end
    rst_n = 0; @(negedge clk);
    chk("t6_rst_buttons", o_buttons, 8'h00);
    chk("t6_rst_pressed", o_pressed, 8'h00);
    chk("t6_rst_count", o_sample_count, 16'h0);
    chk("t6_rst_busy", o_busy, 1'b0);
    chk("t6_rst_irq", o_irq, 1'b0);
    chk("t6_rst_addr", bus.bridge_addr, 2'b00);
    chk("t6_rst_start", bus.bridge_start, 1'b0);
    rst_n = 1;

    // Randomized traffic against the model
    for (int seg = 0; seg < 40; seg++) begin
      enable   = 1'($urandom % 2);
      tb_stuck = ($urandom % 6 == 0);
      tb_lat   = $urandom_range(1, 15);
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        poll_now    = ($urandom % 12 == 0);
        clear       = ($urandom % 20 == 0);
        tb_next_joy = 8'($urandom);
        rst_n       = ($urandom % 500 != 0);
      end
    end
    @(negedge clk);
    poll_now = 0; clear = 0; tb_stuck = 0; rst_n = 1; enable = 1;
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
